tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the DVI transmit path: decodes one TMDS lane back to 8-bit pixel data plus the two control bits. Accepts unaligned 10-bit parallel words from a per-lane 10:1 deserializer in the pixel clock domain. Finds the symbol boundary by locking onto runs of control tokens during blanking, then decodes each symbol. Three instances plus a sync/colour recombiner form the DVI-to-VGA path.

## Interface
- C_lock_tokens, 8: consecutive control tokens required to declare lock.
- C_search_cycles, 4096: cycles without a qualifying token run before advancing offset (SEARCH) or dropping lock (LOCKED); must exceed one full line (2640 at 1920x1080).
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_word  in  10  raw deserialized word; bit 0 is the earliest-received bit.
- out_data  out  8  decoded pixel byte; valid when out_de=1.
- out_c  out  2  decoded control bits {c1,c0}; valid when out_de=0.
- out_de  out  1  1 = data symbol, 0 = control token.
- out_locked  out  1  symbol alignment established.
- out_offset  out  4  current bit offset, 0..9.

## Operation
- Input pipeline: cur <= in_word; prev <= cur each cycle. cat = {cur, prev} (20 bits); window = cat[offset+9 : offset].
- Control tokens (q9..q0): 1101010100 -> c=00, 0010101011 -> c=01, 0101010100 -> c=10, 1010101011 -> c=11.
- Symbol decode (window not a token): d = q9 ? ~q[7:0] : q[7:0]; out[0] = d[0]; for i=1..7, out[i] = q8 ? d[i]^d[i-1] : ~(d[i]^d[i-1]). Every non-token window decodes as data with out_de=1.
- run counter: counts consecutive token windows; clears on a non-token; saturates at C_lock_tokens.
- tmo counter: clears when run reaches C_lock_tokens, on any offset change, and on state change; otherwise increments.
- FSM states:
  - SEARCH (reset state): run reaching C_lock_tokens -> LOCKED.
  - Otherwise, tmo reaching C_search_cycles-1 -> offset advances (9 wraps to 0); run and tmo clear; state stays SEARCH.
  - LOCKED: tmo reaching C_search_cycles-1 -> SEARCH with offset unchanged, so the same offset is re-verified first.
- Simultaneous run threshold and timeout in the same cycle: the threshold wins (lock / stay locked).
- Outputs update every cycle in both states. Downstream consumes them only while out_locked=1.

## Timing
- Reset values: out_data=0, out_c=0, out_de=0, out_locked=0, out_offset=0, state SEARCH, run=0, tmo=0, cur=prev=0.
- Latency: at offset 0, the word presented at cycle n appears on the outputs at n+2.
- At offset k>0, a symbol completes when its later word is registered, also at 2 cycles.
- out_locked rises the cycle after run reaches C_lock_tokens. It falls the cycle after the LOCKED timeout.
- Offset change takes effect on the next window. The output for that one cycle is undefined; out_locked is 0.
- Reset mid-lock: all state returns to reset values on the next edge; no output is held.

## Configuration
- TMDS_DEC_RELOCK_COUNT_EN defined: adds output out_relock_count (8 bits, reset 0).
  - Increments on each LOCKED->SEARCH transition; saturates at 255.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package tmds_pkg:
  - four control-token constants and the token-to-c mapping;
  - the FSM state type {SEARCH, LOCKED};
  - symbol width constant 10.
- Sub-module tmds_symbol_decode: purely combinational, window -> {is_token, c, data}. It is reused by the future TERC4/HDMI decoder.
- Alignment FSM, counters and output registers stay in tmds_channel_decoder.

## Test plan
- Reset with in_word toggling -> all outputs 0, out_offset=0, out_locked=0 while reset high and the cycle after release.
- Aligned stream: 8 x 1101010100 then 0x1FF -> out_locked=1 after the 8th token; out_de=0, out_c=00; then out_de=1, out_data=0x01.
- Data decode while locked: 0x100 -> 0x00; 0x3FF -> 0x00; 0x1FF -> 0x01. Each appears 2 cycles after input with out_de=1.
- Misaligned stream: token stream rotated by 3 bits, C_search_cycles=16 -> out_offset steps 0,1,2,3 one timeout apart; lock at offset 3 with out_c matching the sent tokens.
- Loss of lock: locked at C_search_cycles=16, then 16 data symbols and no tokens -> out_locked drops, out_offset unchanged.
  - With TMDS_DEC_RELOCK_COUNT_EN: out_relock_count goes 0 -> 1.
  - Resending 8 tokens re-locks at the same offset.
- Simultaneous events: 8th token arrives on the timeout cycle -> stays LOCKED / locks; offset does not advance.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens, token-to-c lookup, alignment FSM states.
package tmds_pkg;

   localparam int unsigned SYM_W = 10;

   localparam logic [SYM_W-1:0] TOK_C00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] TOK_C01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] TOK_C10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] TOK_C11 = 10'b1010101011;

   typedef enum logic {SEARCH, LOCKED} state_t;

   typedef struct packed {
      logic       is_token;
      logic [1:0] c;
   } token_t;

   function automatic token_t token_lookup(input logic [SYM_W-1:0] q);
      token_t t;
      t.is_token = 1'b1;
      t.c        = 2'b00;
      case (q)
         TOK_C00: t.c = 2'b00;
         TOK_C01: t.c = 2'b01;
         TOK_C10: t.c = 2'b10;
         TOK_C11: t.c = 2'b11;
         default: t.is_token = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: 10-bit window -> token flag, control bits, data byte.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] window,
   output logic             is_token,
   output logic [1:0]       c,
   output logic [7:0]       data
);

   token_t     tok;
   logic [7:0] d;

   always_comb begin
      tok      = token_lookup(window);
      is_token = tok.is_token;
      c        = tok.c;
      d        = window[9] ? ~window[7:0] : window[7:0];
      data     = '0;
      data[0]  = d[0];
      // q8 selects XOR vs XNOR chaining used by the encoder
      for (int unsigned i = 1; i < 8; i++) begin
         data[i] = window[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane: symbol alignment by control-token runs, then per-symbol decode.
// Optional TMDS_DEC_RELOCK_COUNT_EN adds a saturating LOCKED->SEARCH counter output.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned C_lock_tokens   = 8,
   parameter int unsigned C_search_cycles = 4096
) (
   input  logic             clk_pixel,
   input  logic             reset,
   input  logic [SYM_W-1:0] in_word,
   output logic [7:0]       out_data,
   output logic [1:0]       out_c,
   output logic             out_de,
   output logic             out_locked,
   output logic [3:0]       out_offset
`ifdef TMDS_DEC_RELOCK_COUNT_EN
  ,output logic [7:0]       out_relock_count
`endif
);

   localparam int unsigned RUN_W = $clog2(C_lock_tokens + 1);
   localparam int unsigned TMO_W = $clog2(C_search_cycles);

   logic [SYM_W-1:0]   cur, prev, window;
   logic [2*SYM_W-1:0] cat;
   logic [4:0]         sel;
   logic [3:0]         offset, offset_nxt;
   logic [RUN_W-1:0]   run, run_nxt;
   logic [TMO_W-1:0]   tmo, tmo_nxt;
   state_t             state, state_nxt;
   logic               hit, timeout;
   logic               is_token;
   logic [1:0]         dec_c;
   logic [7:0]         dec_data;

   assign cat        = {cur, prev};
   assign sel        = {1'b0, offset};
   assign window     = cat[sel +: SYM_W];
   assign out_offset = offset;

   tmds_symbol_decode u_dec (
      .window   (window),
      .is_token (is_token),
      .c        (dec_c),
      .data     (dec_data)
   );

   always_comb begin
      run_nxt    = '0;
      if (is_token) begin
         run_nxt = (run == RUN_W'(C_lock_tokens)) ? run : run + 1'b1;
      end
      hit        = (run_nxt == RUN_W'(C_lock_tokens));
      timeout    = (tmo == TMO_W'(C_search_cycles - 1));
      state_nxt  = state;
      offset_nxt = offset;
      tmo_nxt    = tmo + 1'b1;
      // token threshold takes priority over a coincident timeout
      case (state)
         SEARCH: begin
            if (hit) begin
               state_nxt = LOCKED;
               tmo_nxt   = '0;
            end else if (timeout) begin
               offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
               run_nxt    = '0;
               tmo_nxt    = '0;
            end
         end
         LOCKED: begin
            if (hit) begin
               tmo_nxt = '0;
            end else if (timeout) begin
               state_nxt = SEARCH;
               tmo_nxt   = '0;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cur        <= '0;
         prev       <= '0;
         state      <= SEARCH;
         offset     <= '0;
         run        <= '0;
         tmo        <= '0;
         out_data   <= '0;
         out_c      <= '0;
         out_de     <= 1'b0;
         out_locked <= 1'b0;
      end else begin
         cur        <= in_word;
         prev       <= cur;
         state      <= state_nxt;
         offset     <= offset_nxt;
         run        <= run_nxt;
         tmo        <= tmo_nxt;
         out_data   <= dec_data;
         out_c      <= dec_c;
         out_de     <= ~is_token;
         out_locked <= (state_nxt == LOCKED);
      end
   end

`ifdef TMDS_DEC_RELOCK_COUNT_EN
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         out_relock_count <= '0;
      end else if (state == LOCKED && state_nxt == SEARCH && out_relock_count != '1) begin
         out_relock_count <= out_relock_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder (C_search_cycles=16); covers TMDS_DEC_RELOCK_COUNT_EN when defined.
module tb_tmds_channel_decoder;

   logic       clk_pixel = 1'b0;
   logic       reset     = 1'b1;
   logic [9:0] in_word   = '0;
   logic [7:0] out_data;
   logic [1:0] out_c;
   logic       out_de;
   logic       out_locked;
   logic [3:0] out_offset;
`ifdef TMDS_DEC_RELOCK_COUNT_EN
   logic [7:0] out_relock_count;
`endif

   int checks = 0;
   int errors = 0;

   tmds_channel_decoder #(
      .C_lock_tokens   (8),
      .C_search_cycles (16)
   ) dut (
      .clk_pixel  (clk_pixel),
      .reset      (reset),
      .in_word    (in_word),
      .out_data   (out_data),
      .out_c      (out_c),
      .out_de     (out_de),
      .out_locked (out_locked),
      .out_offset (out_offset)
`ifdef TMDS_DEC_RELOCK_COUNT_EN
     ,.out_relock_count (out_relock_count)
`endif
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic tick(input logic [9:0] w);
      in_word = w;
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] w;

      // reset held with toggling input
      for (int i = 0; i < 3; i++) begin
         tick((i % 2 == 0) ? 10'h354 : 10'h2AB);
         check("rst_data", 32'(out_data), 32'h00);
         check("rst_c", 32'(out_c), 32'h0);
         check("rst_de", 32'(out_de), 32'h0);
         check("rst_locked", 32'(out_locked), 32'h0);
         check("rst_offset", 32'(out_offset), 32'h0);
      end
      reset = 1'b0;
      check("rel_data", 32'(out_data), 32'h00);
      check("rel_de", 32'(out_de), 32'h0);

      // aligned lock, data decode, loss of lock, relock
      for (int t = 1; t <= 36; t++) begin
         case (t)
            1, 5:    w = 10'h354;
            2, 6:    w = 10'h0AB;
            3, 7:    w = 10'h154;
            4, 8:    w = 10'h2AB;
            9:       w = 10'h1FF;
            10:      w = 10'h100;
            11:      w = 10'h3FF;
            12:      w = 10'h0F0;
            13:      w = 10'h1F0;
            14:      w = 10'h155;
            15:      w = 10'h2AA;
            16:      w = 10'h000;
            default: w = (t >= 27) ? 10'h354 : 10'h1FF;
         endcase
         tick(w);
         case (t)
            1: begin
               check("post_rel_locked", 32'(out_locked), 32'h0);
               check("post_rel_offset", 32'(out_offset), 32'h0);
            end
            3: begin
               check("tok00_de", 32'(out_de), 32'h0);
               check("tok00_c", 32'(out_c), 32'h0);
            end
            4:  check("tok01_c", 32'(out_c), 32'h1);
            5:  check("tok10_c", 32'(out_c), 32'h2);
            6:  check("tok11_c", 32'(out_c), 32'h3);
            9:  check("pre_lock", 32'(out_locked), 32'h0);
            10: begin
               check("lock_rise", 32'(out_locked), 32'h1);
               check("lock_de", 32'(out_de), 32'h0);
               check("lock_c", 32'(out_c), 32'h3);
            end
            11: begin
               check("d1ff_de", 32'(out_de), 32'h1);
               check("d1ff", 32'(out_data), 32'h01);
            end
            12: check("d100", 32'(out_data), 32'h00);
            13: check("d3ff", 32'(out_data), 32'h00);
            14: check("d0f0", 32'(out_data), 32'hEE);
            15: check("d1f0", 32'(out_data), 32'h10);
            16: check("d155", 32'(out_data), 32'hFF);
            17: check("d2aa", 32'(out_data), 32'h01);
            18: begin
               check("d000", 32'(out_data), 32'hFE);
               check("d000_de", 32'(out_de), 32'h1);
               check("data_locked", 32'(out_locked), 32'h1);
            end
            25: check("lol_hold", 32'(out_locked), 32'h1);
            26: begin
               check("lol_drop", 32'(out_locked), 32'h0);
               check("lol_offset", 32'(out_offset), 32'h0);
`ifdef TMDS_DEC_RELOCK_COUNT_EN
               check("relock_cnt", 32'(out_relock_count), 32'h1);
`endif
            end
            35: check("relock_pre", 32'(out_locked), 32'h0);
            36: begin
               check("relock", 32'(out_locked), 32'h1);
               check("relock_offset", 32'(out_offset), 32'h0);
               check("relock_c", 32'(out_c), 32'h0);
`ifdef TMDS_DEC_RELOCK_COUNT_EN
               check("relock_cnt_hold", 32'(out_relock_count), 32'h1);
`endif
            end
            default: ;
         endcase
      end

      // reset while locked
      reset = 1'b1;
      tick(10'h354);
      check("midrst_locked", 32'(out_locked), 32'h0);
      check("midrst_offset", 32'(out_offset), 32'h0);
      check("midrst_de", 32'(out_de), 32'h0);
      check("midrst_c", 32'(out_c), 32'h0);
      check("midrst_data", 32'(out_data), 32'h00);
`ifdef TMDS_DEC_RELOCK_COUNT_EN
      check("midrst_cnt", 32'(out_relock_count), 32'h0);
`endif
      reset = 1'b0;

      // threshold coinciding with timeout, in SEARCH then in LOCKED
      for (int t = 1; t <= 34; t++) begin
         w = ((t >= 7 && t <= 14) || t >= 23) ? 10'h354 : 10'h1FF;
         tick(w);
         case (t)
            15: begin
               check("sim_pre_locked", 32'(out_locked), 32'h0);
               check("sim_pre_offset", 32'(out_offset), 32'h0);
            end
            16: begin
               check("sim_search_lock", 32'(out_locked), 32'h1);
               check("sim_search_offset", 32'(out_offset), 32'h0);
            end
            31: check("sim_l31", 32'(out_locked), 32'h1);
            32: check("sim_locked_hold", 32'(out_locked), 32'h1);
            34: check("sim_l34", 32'(out_locked), 32'h1);
            default: ;
         endcase
      end

      reset = 1'b1;
      tick(10'h000);
      reset = 1'b0;

      // token 0x154 arriving 3 bits into each word
      for (int t = 1; t <= 56; t++) begin
         tick(10'h2A2);
         case (t)
            15: check("mis_off0", 32'(out_offset), 32'h0);
            16: begin
               check("mis_off1", 32'(out_offset), 32'h1);
               check("mis_unlocked", 32'(out_locked), 32'h0);
            end
            31: check("mis_off1_hold", 32'(out_offset), 32'h1);
            32: check("mis_off2", 32'(out_offset), 32'h2);
            47: check("mis_off2_hold", 32'(out_offset), 32'h2);
            48: check("mis_off3", 32'(out_offset), 32'h3);
            55: check("mis_pre_lock", 32'(out_locked), 32'h0);
            56: begin
               check("mis_lock", 32'(out_locked), 32'h1);
               check("mis_de", 32'(out_de), 32'h0);
               check("mis_c", 32'(out_c), 32'h2);
               check("mis_offset", 32'(out_offset), 32'h3);
            end
            default: ;
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
